// File: rtl/mux_scan_sampler_if.sv
// -----------------------------------------------------------------------------
// mux_scan_sampler_if
// Bundles the channel inputs, the mode/select controls and the registered
// sample outputs of mux_scan_sampler.
//   master : drives data_in, mode, sel_in, load, hold (and ch_mask);
//            receives data_out, sel_out, valid, wrap.
//   slave  : the sampler side, directions mirrored.
// Optional macro SCAN_MASK_EN adds the per-channel scan enable ch_mask.
// -----------------------------------------------------------------------------
interface mux_scan_sampler_if #(
  parameter int NUM_CH = 8,
  parameter int WIDTH  = 1
);
  localparam int SEL_W = $clog2(NUM_CH);

  logic [NUM_CH*WIDTH-1:0] data_in;
  logic                    mode;
  logic [SEL_W-1:0]        sel_in;
  logic                    load;
  logic                    hold;
`ifdef SCAN_MASK_EN
  logic [NUM_CH-1:0]       ch_mask;
`endif
  logic [WIDTH-1:0]        data_out;
  logic [SEL_W-1:0]        sel_out;
  logic                    valid;
  logic                    wrap;

`ifdef SCAN_MASK_EN
  modport master (output data_in, mode, sel_in, load, hold, ch_mask,
                  input  data_out, sel_out, valid, wrap);
  modport slave  (input  data_in, mode, sel_in, load, hold, ch_mask,
                  output data_out, sel_out, valid, wrap);
`else
  modport master (output data_in, mode, sel_in, load, hold,
                  input  data_out, sel_out, valid, wrap);
  modport slave  (input  data_in, mode, sel_in, load, hold,
                  output data_out, sel_out, valid, wrap);
`endif
endinterface

// File: rtl/mux_scan_sampler.sv
// -----------------------------------------------------------------------------
// mux_scan_sampler
// Registered NUM_CH:1 multiplexer with a manual (explicit load) mode and an
// automatic scan mode that dwells DWELL cycles per channel. The sample is
// registered together with the channel index it came from.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : mux_scan_sampler_if.slave (data_in, mode, sel_in, load, hold,
//           [ch_mask], data_out, sel_out, valid, wrap)
// Optional macro SCAN_MASK_EN: scan advance skips channels whose ch_mask bit
// is 0. Without it every channel is scanned.
// -----------------------------------------------------------------------------
module mux_scan_sampler #(
  parameter  int NUM_CH = 8,
  parameter  int WIDTH  = 1,
  parameter  int DWELL  = 4,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input logic               clk,
  input logic               rst_n,
  mux_scan_sampler_if.slave bus
);
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_MAN, ST_SCAN} state_t;

  state_t            r_state, w_state_next;
  logic [SEL_W-1:0]  r_sel, w_sel_next;
  logic [DW_W-1:0]   r_dwell, w_dwell_next;
  logic              r_wrap_pend, w_wrap_pend_next;

  logic [WIDTH-1:0]  r_data;
  logic [SEL_W-1:0]  r_sel_out;
  logic              r_valid;
  logic              r_wrap;

  logic [WIDTH-1:0]  w_ch [NUM_CH];
  logic [NUM_CH-1:0] w_en;
  logic              w_any_en;
  logic              w_adv_found;
  logic [SEL_W-1:0]  w_adv_sel;
  logic              w_sel_in_ok;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign w_ch[gi] = bus.data_in[gi*WIDTH +: WIDTH];
  end

`ifdef SCAN_MASK_EN
  assign w_en = bus.ch_mask;
`else
  assign w_en = '1;
`endif
  assign w_any_en = |w_en;

  // Out-of-range selects only exist for non-power-of-2 channel counts.
  assign w_sel_in_ok = (int'(bus.sel_in) < NUM_CH);

  // Next enabled channel after r_sel, circular ascending. Scanning offsets
  // from far to near lets the nearest enabled channel win. The current
  // channel itself is never a candidate, so a lone enabled channel holds.
  always_comb begin
    w_adv_found = 1'b0;
    w_adv_sel   = r_sel;
    for (int k = NUM_CH - 1; k >= 1; k--) begin
      if (w_en[(int'(r_sel) + k) % NUM_CH]) begin
        w_adv_found = 1'b1;
        w_adv_sel   = SEL_W'((int'(r_sel) + k) % NUM_CH);
      end
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_sel_next       = r_sel;
    w_dwell_next     = r_dwell;
    w_wrap_pend_next = 1'b0;
    case (r_state)
      ST_IDLE: w_state_next = bus.mode ? ST_SCAN : ST_MAN;
      ST_MAN: begin
        if (bus.load && w_sel_in_ok) w_sel_next = bus.sel_in;
        if (bus.mode) begin
          w_state_next = ST_SCAN;
          w_dwell_next = '0;
        end
      end
      ST_SCAN: begin
        if (!bus.mode) begin
          w_state_next = ST_MAN;
          w_dwell_next = '0;
        end else if (!bus.hold) begin
          if (!w_any_en) begin
            w_dwell_next = '0;
          end else if (r_dwell != DWELL_LAST) begin
            w_dwell_next = r_dwell + 1'b1;
          end else begin
            w_dwell_next = '0;
            if (w_adv_found) begin
              w_sel_next       = w_adv_sel;
              w_wrap_pend_next = (w_adv_sel < r_sel);
            end
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_sel       <= '0;
      r_dwell     <= '0;
      r_wrap_pend <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_sel       <= w_sel_next;
      r_dwell     <= w_dwell_next;
      r_wrap_pend <= w_wrap_pend_next;
    end
  end

  // Output stage samples the channel selected before this edge, so the
  // pending wrap flag lines up with the first sample of the new channel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_sel_out <= '0;
      r_valid   <= 1'b0;
      r_wrap    <= 1'b0;
    end else if (r_state != ST_IDLE) begin
      r_data    <= w_ch[r_sel];
      r_sel_out <= r_sel;
      r_valid   <= 1'b1;
      r_wrap    <= r_wrap_pend;
    end
  end

  assign bus.data_out = r_data;
  assign bus.sel_out  = r_sel_out;
  assign bus.valid    = r_valid;
  assign bus.wrap     = r_wrap;
endmodule

// File: tb/tb_mux_scan_sampler.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_sampler
// Directed scenarios followed by randomized stimulus, every cycle compared
// against a channel/dwell reference model kept in plain integers.
// -----------------------------------------------------------------------------
module tb_mux_scan_sampler;
  localparam int NUM_CH = 8;
  localparam int WIDTH  = 4;
  localparam int DWELL  = 3;
  localparam int SEL_W  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0]  ch_val [NUM_CH];
  logic [NUM_CH-1:0] mask_v = '1;

  mux_scan_sampler_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus ();

  mux_scan_sampler #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DWELL(DWELL)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_drv
    assign bus.data_in[gi*WIDTH +: WIDTH] = ch_val[gi];
  end
`ifdef SCAN_MASK_EN
  assign bus.ch_mask = mask_v;
`endif

  // Reference model: which channel is current, how many cycles it has been
  // dwelt on, and what the registered outputs should show.
  int m_active = 0, m_scan = 0, m_ch = 0, m_cnt = 0, m_pend = 0;
  int e_data = 0, e_sel = 0, e_valid = 0, e_wrap = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int next_on(input int c);
    for (int off = 1; off < NUM_CH; off++) begin
      if (mask_v[(c + off) % NUM_CH]) return (c + off) % NUM_CH;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int nx;
    if (!rst_n) begin
      m_active = 0; m_scan = 0; m_ch = 0; m_cnt = 0; m_pend = 0;
      e_data = 0; e_sel = 0; e_valid = 0; e_wrap = 0;
    end else if (m_active == 0) begin
      m_active = 1;
      m_scan   = int'(bus.mode);
    end else begin
      e_data  = int'(ch_val[m_ch]);
      e_sel   = m_ch;
      e_valid = 1;
      e_wrap  = m_pend;
      m_pend  = 0;
      if (m_scan == 0) begin
        if (bus.load && int'(bus.sel_in) < NUM_CH) m_ch = int'(bus.sel_in);
        if (bus.mode) begin m_scan = 1; m_cnt = 0; end
      end else if (!bus.mode) begin
        m_scan = 0; m_cnt = 0;
      end else if (!bus.hold) begin
        if (mask_v == '0) m_cnt = 0;
        else if (m_cnt < DWELL - 1) m_cnt++;
        else begin
          m_cnt = 0;
          nx = next_on(m_ch);
          if (nx >= 0) begin
            if (nx < m_ch) m_pend = 1;
            m_ch = nx;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("data_out", 32'(bus.data_out), e_data);
    check("sel_out",  32'(bus.sel_out),  e_sel);
    check("valid",    32'(bus.valid),    e_valid);
    check("wrap",     32'(bus.wrap),     e_wrap);
  endtask

  task automatic run(input int n, output int wraps);
    wraps = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (bus.wrap) wraps++;
    end
  endtask

  initial begin
    int w;
    for (int k = 0; k < NUM_CH; k++) ch_val[k] = WIDTH'(k + 8);
    bus.mode = 1'b0; bus.sel_in = '0; bus.load = 1'b0; bus.hold = 1'b0;

    // 1: reset, manual load of channel 5
    rst_n = 1'b0;
    run(3, w);
    check("rst_valid", 32'(bus.valid), 0);
    check("rst_data", 32'(bus.data_out), 0);
    rst_n = 1'b1;
    step();                                   // IDLE -> MAN
    bus.sel_in = 3'd5; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    step();
    check("t1_data", 32'(bus.data_out), 32'hD);
    check("t1_sel", 32'(bus.sel_out), 5);
    check("t1_valid", 32'(bus.valid), 1);

    // 2: full scan from channel 0, exactly one wrap
    rst_n = 1'b0; step(); rst_n = 1'b1;
    bus.mode = 1'b1;
    run(26, w);
    check("t2_wrap_cnt", w, 1);
    check("t2_wrap_sel", 32'(bus.sel_out), 0);
    check("t2_wrap_data", 32'(bus.data_out), 32'h8);

    // 3: hold on channel 3 while its data moves
    bus.mode = 1'b0; step();
    bus.sel_in = 3'd3; bus.load = 1'b1; step(); bus.load = 1'b0;
    bus.mode = 1'b1; step();
    bus.hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ch_val[3] = WIDTH'($urandom);
      step();
    end
    check("t3_hold_sel", 32'(bus.sel_out), 3);
    bus.hold = 1'b0; ch_val[3] = 4'hB;
    run(4, w);
    check("t3_adv_sel", 32'(bus.sel_out), 4);

    // 4: reset mid-scan at channel 6
    run(6, w);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check("t4_valid", 32'(bus.valid), 0);
    check("t4_sel", 32'(bus.sel_out), 0);
    run(5, w);

    // 5: manual load 2, then scan; loads during scan ignored
    bus.mode = 1'b0; step();
    bus.sel_in = 3'd2; bus.load = 1'b1; step(); bus.load = 1'b0;
    bus.mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.load = 1'b1; bus.sel_in = 3'd6;
      step();
    end
    bus.load = 1'b0;

`ifdef SCAN_MASK_EN
    // 6: masked scan 0,2,7,0 then all channels masked
    rst_n = 1'b0; step(); rst_n = 1'b1;
    mask_v = 8'b1000_0101;
    run(11, w);
    check("t6_wrap_cnt", w, 1);
    check("t6_sel", 32'(bus.sel_out), 0);
    mask_v = '0;
    run(8, w);
    check("t6_zero_wrap", w, 0);
    mask_v = '1;
`endif

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      rst_n = ($urandom_range(63) != 0);
      if ($urandom_range(15) == 0) bus.mode = ~bus.mode;
      bus.load   = ($urandom_range(2) == 0);
      bus.sel_in = SEL_W'($urandom);
      bus.hold   = ($urandom_range(4) == 0);
      for (int k = 0; k < NUM_CH; k++)
        if ($urandom_range(3) == 0) ch_val[k] = WIDTH'($urandom);
`ifdef SCAN_MASK_EN
      if ($urandom_range(19) == 0) begin
        case ($urandom_range(3))
          0:       mask_v = '0;
          1:       mask_v = NUM_CH'(1) << $urandom_range(NUM_CH - 1);
          default: mask_v = NUM_CH'($urandom);
        endcase
      end
`endif
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mux_scan_sampler.md
Name: mux_scan_sampler

Overview:
Parametrised registered N:1 multiplexer. It is the sequential successor of the combinational mux tree: NUM_CH channels, each WIDTH bits wide.
- Manual mode: the channel is selected by an explicit load.
- Scan mode: the block steps through the channels automatically, dwelling DWELL cycles on each.
- The sampled data is registered together with its channel index. The block feeds the display/readout path of the lab designs.

Parameters:
NUM_CH, 8, number of input channels (>=2).
WIDTH, 1, bits per channel.
DWELL, 4, cycles spent on each channel in scan mode (>=1).
SEL_W, $clog2(NUM_CH), select width (derived; not to be overridden).

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  synchronous active-low reset.
data_in  in  NUM_CH*WIDTH  packed channels; channel k = data_in[k*WIDTH +: WIDTH].
mode  in  1  0 = manual, 1 = scan.
sel_in  in  SEL_W  channel to load in manual mode.
load  in  1  manual-mode strobe; captures sel_in.
hold  in  1  scan mode only: freezes the dwell counter and channel advance.
ch_mask  in  NUM_CH  per-channel scan enable (present only with SCAN_MASK_EN).
data_out  out  WIDTH  registered sample of the selected channel.
sel_out  out  SEL_W  channel index that data_out was sampled from.
valid  out  1  data_out/sel_out hold a real sample.
wrap  out  1  one-cycle pulse, scan mode, aligned with the first sample after wrapping to a lower index.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at an edge):
  - state=IDLE, sel_q=0, dwell_q=0.
  - data_out=0, sel_out=0, valid=0, wrap=0.
  - Reset mid-scan aborts immediately; no partial dwell is retained.
- Internal registers: sel_q (current channel) and dwell_q (0..DWELL-1).
- Datapath, every edge outside reset and IDLE:
  - data_out<=data_in[sel_q], sel_out<=sel_q, valid<=1.
  - data_out is therefore always aligned with sel_out.
- FSM:
  - IDLE: exits after one cycle to MAN if mode=0, or to SCAN if mode=1. valid stays 0 while in IDLE.
  - MAN: if load=1, sel_q<=sel_in at the edge. A load at edge t appears on data_out/sel_out at edge t+1 (2-cycle latency from the load cycle). If sel_in>=NUM_CH (non-power-of-2 NUM_CH), the load is ignored and sel_q is kept. hold is ignored in MAN.
  - SCAN:
    - hold=1: dwell_q and sel_q are frozen; the datapath keeps sampling.
    - hold=0 and dwell_q<DWELL-1: dwell_q increments.
    - hold=0 and dwell_q==DWELL-1: dwell_q<=0 and sel_q<=next channel, circular ascending (NUM_CH-1 -> 0).
    - load is ignored in SCAN.
  - Mode change: takes effect at the next edge. MAN->SCAN starts from the current sel_q with dwell_q=0. SCAN->MAN keeps sel_q and clears dwell_q. valid stays 1 across mode changes.
- wrap:
  - Generated internally when sel_q advances to a lower index.
  - Delayed one stage so it is high in the same cycle sel_out first shows the new index.
  - Never asserted in MAN.
- DWELL=1: the channel advances every cycle.

Optional Feature:
Macro name: SCAN_MASK_EN.
- Defined:
  - ch_mask port exists.
  - The scan advance goes to the next index with ch_mask=1, searching circularly and ascending.
  - If only the current channel is enabled, sel_q is held but dwell still cycles; no wrap.
  - If ch_mask is all zero, sel_q holds, dwell_q holds at 0, and no wrap occurs.
  - MAN ignores ch_mask; a masked channel can still be loaded.
  - wrap still fires whenever the advance goes to a lower index.
- Undefined: ch_mask port absent; all channels are treated as enabled.

Test Plan:
All scenarios use NUM_CH=8, WIDTH=4, DWELL=3, data_in channel k = k+8 (0x8..0xF).
1. Reset, then mode=0, load with sel_in=5 -> two edges after load: data_out=0xD, sel_out=5, valid=1. Before reset release: all outputs 0, valid=0.
2. mode=1 from sel_q=0, hold=0 for 24 cycles -> sel_out 0..7, each held 3 cycles. wrap pulses exactly once, in the cycle sel_out returns to 0 showing data_out=0x8.
3. SCAN on channel 3 with hold=1 for 10 cycles -> sel_out stays 3, data_out follows changes on channel 3. After release, the advance to 4 occurs once the remaining dwell cycles complete.
4. rst_n=0 for one edge mid-scan at channel 6 -> next cycle valid=0, sel_out=0, wrap=0. IDLE, then a restart from channel 0.
5. Manual load sel_in=2, then switch to mode=1 -> scan starts on channel 2 with a full 3-cycle dwell. A load asserted during SCAN has no effect.
6. (SCAN_MASK_EN) ch_mask=8'b1000_0101, scan -> sel_out sequence 0,2,7,0 with wrap on the return to 0. ch_mask=0 -> sel_out frozen, no wrap.
